led_pattern_player: RTL and testbench

- Downstream consumer of the serial command block, clocked in the same clock domain.
- Holds the 256-entry x 72-bit stored pattern RAM that the serial block writes, and steps through it at a frame rate.
- Selects one of four frame sources (free running, stored, random, individual) and drives 24 LEDs with 3-bit PWM brightness.
- Each 72-bit frame is 24 LEDs x 3 bits; LED i uses bits [3i+2:3i].

---
 rtl/led_pattern_player.sv | 163 ++++++++++++++++
 tb/tb_led_pattern_player.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_player.sv
// LED pattern player: steps a 256 x 72-bit pattern RAM at a frame rate, selects one of
// four frame sources and drives 24 LEDs with 3-bit, 7-slot PWM brightness.
module led_pattern_player #(
  parameter logic [15:0] FRAME_DIV    = 16'd50000,
  parameter logic [7:0]  PWM_DIV      = 8'd16,
  parameter logic [7:0]  PATTERN_LAST = 8'd255,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  a,
  input  logic [71:0] d,
  input  logic        we,
  input  logic [1:0]  pattern_type,
  input  logic [71:0] specific_led_values,
  output logic [23:0] led,
  output logic        frame_tick
);

  localparam logic [15:0] FRAME_LAST = FRAME_DIV - 16'd1;
  localparam logic [15:0] FRAME_PRE  = FRAME_DIV - 16'd2;
  localparam logic [7:0]  PWM_LAST   = PWM_DIV - 8'd1;
  localparam logic [2:0]  SLOT_LAST  = 3'd6;

  localparam logic [1:0]  SRC_FREE   = 2'd0;
  localparam logic [1:0]  SRC_STORED = 2'd1;
  localparam logic [1:0]  SRC_RANDOM = 2'd2;

  logic [15:0] r_frame_cnt;
  logic        r_frame_tick;
  logic [7:0]  r_play_addr;
  logic [2:0]  r_chase;
  logic [15:0] r_lfsr;
  logic [71:0] r_rnd;
  logic [71:0] r_mem [0:255];
  logic [71:0] r_ram_q;
  logic [7:0]  r_slot_div;
  logic [2:0]  r_slot;
  logic [71:0] r_shown;
  logic [23:0] r_led;

  logic        w_lfsr_fb;
  logic [71:0] w_src;
  logic        w_slot_tick;
  logic        w_boundary;
  logic [2:0]  w_slot_nxt;
  logic [71:0] w_shown_nxt;
  logic [23:0] w_led_nxt;

  // Fibonacci LFSR feedback for taps 16,14,13,11.
  function automatic logic lfsr_feedback(input logic [15:0] state);
    lfsr_feedback = state[15] ^ state[13] ^ state[12] ^ state[10];
  endfunction

  assign w_lfsr_fb   = lfsr_feedback(r_lfsr);
  assign w_slot_tick = (r_slot_div == PWM_LAST);
  assign w_boundary  = w_slot_tick && (r_slot == SLOT_LAST);

  // frame_tick is registered one cycle early so it is high exactly while frame_cnt is at its last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt  <= 16'd0;
      r_frame_tick <= 1'b0;
    end else begin
      if (r_frame_tick) begin
        r_frame_cnt <= 16'd0;
      end else begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      r_frame_tick <= (r_frame_cnt == FRAME_PRE) && (r_frame_cnt != FRAME_LAST);
    end
  end

  // Per-frame state: playback address, chase phase, LFSR and random history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_play_addr <= 8'd0;
      r_chase     <= 3'd0;
      r_lfsr      <= LFSR_SEED;
      r_rnd       <= 72'd0;
    end else if (r_frame_tick) begin
      r_play_addr <= (r_play_addr == PATTERN_LAST) ? 8'd0 : r_play_addr + 8'd1;
      r_chase     <= r_chase + 3'd1;
      r_lfsr      <= {r_lfsr[14:0], w_lfsr_fb};
      r_rnd       <= {r_rnd[68:0], r_lfsr[2:0]};
    end else begin
      r_play_addr <= r_play_addr;
      r_chase     <= r_chase;
      r_lfsr      <= r_lfsr;
      r_rnd       <= r_rnd;
    end
  end

  // Pattern RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[a] <= d;
    end
  end

  // Read-first RAM output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ram_q <= 72'd0;
    end else begin
      r_ram_q <= r_mem[r_play_addr];
    end
  end

  // Frame source select.
  always_comb begin
    w_src = 72'd0;
    case (pattern_type)
      SRC_FREE: begin
        for (int i = 0; i < 24; i++) begin
          w_src[3*i +: 3] = r_chase + 3'(i);
        end
      end
      SRC_STORED: w_src = r_ram_q;
      SRC_RANDOM: w_src = r_rnd;
      default:    w_src = specific_led_values;
    endcase
  end

  // Next slot/shown values; shown only reloads at a PWM period boundary.
  always_comb begin
    w_slot_nxt  = r_slot;
    w_shown_nxt = r_shown;
    w_led_nxt   = 24'd0;
    if (w_boundary) begin
      w_slot_nxt  = 3'd0;
      w_shown_nxt = w_src;
    end else if (w_slot_tick) begin
      w_slot_nxt  = r_slot + 3'd1;
      w_shown_nxt = r_shown;
    end else begin
      w_slot_nxt  = r_slot;
      w_shown_nxt = r_shown;
    end
    for (int i = 0; i < 24; i++) begin
      w_led_nxt[i] = (w_slot_nxt < w_shown_nxt[3*i +: 3]);
    end
  end

  // PWM slot divider, slot counter, latched frame and LED drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_div <= 8'd0;
      r_slot     <= 3'd0;
      r_shown    <= 72'd0;
      r_led      <= 24'd0;
    end else begin
      r_slot_div <= w_slot_tick ? 8'd0 : r_slot_div + 8'd1;
      r_slot     <= w_slot_nxt;
      r_shown    <= w_shown_nxt;
      r_led      <= w_led_nxt;
    end
  end

  assign led        = r_led;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_led_pattern_player.sv
// Self-checking bench for led_pattern_player: a cycle-indexed reference model pushes the
// expected {frame_tick, led} per clock and each test task pops and compares.
module tb_led_pattern_player;

  localparam int FD = 20;
  localparam int PD = 2;
  localparam int PL = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  a = 8'd0;
  logic [71:0] d = 72'd0;
  logic        we = 1'b0;
  logic [1:0]  pattern_type = 2'd3;
  logic [71:0] specific_led_values = 72'd0;
  logic [23:0] led;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [24:0] sb_q [$];
  logic [24:0] exp_v;
  logic [71:0] m_mem [0:255];
  logic [71:0] m_ram_q = 72'd0;
  logic [71:0] m_shown = 72'd0;
  logic [15:0] seq [0:127];

  led_pattern_player #(
    .FRAME_DIV(16'd20),
    .PWM_DIV(8'd2),
    .PATTERN_LAST(8'd2),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .d(d),
    .we(we),
    .pattern_type(pattern_type),
    .specific_led_values(specific_led_values),
    .led(led),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model for one clock: expected outputs of the next cycle are queued.
  task automatic step();
    logic [71:0] src;
    logic [71:0] shown_n;
    logic [23:0] led_n;
    logic        tick_n;
    int fr;
    fr = cyc / FD;
    src = 72'd0;
    case (pattern_type)
      2'd0: for (int i = 0; i < 24; i++) src[3*i +: 3] = 3'((fr + i) % 8);
      2'd1: src = m_ram_q;
      2'd2: for (int j = 0; j < 24; j++) if (fr - 1 - j >= 0) src[3*j +: 3] = seq[fr - 1 - j][2:0];
      default: src = specific_led_values;
    endcase
    shown_n = (cyc % (7 * PD) == 7 * PD - 1) ? src : m_shown;
    for (int i = 0; i < 24; i++) led_n[i] = (((cyc + 1) / PD) % 7) < int'(shown_n[3*i +: 3]);
    tick_n = (((cyc + 1) % FD) == FD - 1);
    sb_q.push_back({tick_n, led_n});
    m_ram_q = m_mem[fr % (PL + 1)];
    if (we) m_mem[a] = d;
    m_shown = shown_n;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({frame_tick, led} !== 25'd0) begin
        errors++;
        $display("FAIL reset_hold got=%h exp=%h", {frame_tick, led}, 25'd0);
      end
    end
    rst = 1'b0;
    cyc = 0;
    m_ram_q = 72'd0;
    m_shown = 72'd0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    int first_tick;
    int n_ticks;
    first_tick = -1;
    n_ticks = 0;
    pattern_type = 2'd3;
    specific_led_values = 72'd0;
    do_reset();
    checks++;
    if ({frame_tick, led} !== 25'd0) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", {frame_tick, led}, 25'd0);
    end
    for (int k = 0; k < 60; k++) begin
      step();
      exp_v = sb_q.pop_front();
      checks++;
      if ({frame_tick, led} !== exp_v) begin
        errors++;
        $display("FAIL reset_run cyc=%0d got=%h exp=%h", cyc, {frame_tick, led}, exp_v);
      end
      if (frame_tick === 1'b1) begin
        n_ticks++;
        if (first_tick < 0) first_tick = cyc;
      end
    end
    checks++;
    if (first_tick !== 19) begin
      errors++;
      $display("FAIL first_tick got=%0d exp=%0d", first_tick, 19);
    end
    checks++;
    if (n_ticks !== 3) begin
      errors++;
      $display("FAIL tick_count got=%0d exp=%0d", n_ticks, 3);
    end
  endtask

  task automatic test_individual();
    int c0, c1, c2;
    c0 = 0; c1 = 0; c2 = 0;
    pattern_type = 2'd3;
    specific_led_values = 72'h1F;
    do_reset();
    for (int k = 0; k < 28; k++) begin
      step();
      exp_v = sb_q.pop_front();
      checks++;
      if ({frame_tick, led} !== exp_v) begin
        errors++;
        $display("FAIL indiv_led cyc=%0d got=%h exp=%h", cyc, {frame_tick, led}, exp_v);
      end
      if (cyc >= 14 && cyc <= 27) begin
        c0 += int'(led[0]);
        c1 += int'(led[1]);
        c2 += int'(led[2]);
      end
    end
    checks++;
    if (c0 !== 14) begin errors++; $display("FAIL indiv_duty0 got=%0d exp=%0d", c0, 14); end
    checks++;
    if (c1 !== 6) begin errors++; $display("FAIL indiv_duty1 got=%0d exp=%0d", c1, 6); end
    checks++;
    if (c2 !== 0) begin errors++; $display("FAIL indiv_duty2 got=%0d exp=%0d", c2, 0); end
  endtask

  task automatic test_stored();
    int c0, c1, c2;
    c0 = 0; c1 = 0; c2 = 0;
    pattern_type = 2'd1;
    do_reset();
    for (int k = 0; k < 200; k++) begin
      case (cyc)
        0:  begin we = 1'b1; a = 8'd0; d = 72'h7;   end
        1:  begin we = 1'b1; a = 8'd1; d = 72'h38;  end
        2:  begin we = 1'b1; a = 8'd2; d = 72'h1C0; end
        3:  begin we = 1'b1; a = 8'd3; d = {72{1'b1}}; end
        82: begin we = 1'b1; a = 8'd1; d = {72{1'b1}}; end
        default: we = 1'b0;
      endcase
      step();
      we = 1'b0;
      exp_v = sb_q.pop_front();
      checks++;
      if ({frame_tick, led} !== exp_v) begin
        errors++;
        $display("FAIL stored_led cyc=%0d got=%h exp=%h", cyc, {frame_tick, led}, exp_v);
      end
      if (cyc >= 14 && cyc <= 27) c0 += int'(led[0]);
      if (cyc >= 28 && cyc <= 41) c1 += int'(led[1]);
      if (cyc >= 42 && cyc <= 55) c2 += int'(led[2]);
    end
    checks++;
    if (c0 !== 14) begin errors++; $display("FAIL stored_led0 got=%0d exp=%0d", c0, 14); end
    checks++;
    if (c1 !== 14) begin errors++; $display("FAIL stored_led1 got=%0d exp=%0d", c1, 14); end
    checks++;
    if (c2 !== 14) begin errors++; $display("FAIL stored_led2 got=%0d exp=%0d", c2, 14); end
  endtask

  task automatic test_chase();
    int c9, c7a, c7b;
    c9 = 0; c7a = 0; c7b = 0;
    pattern_type = 2'd0;
    do_reset();
    for (int k = 0; k < 42; k++) begin
      step();
      exp_v = sb_q.pop_front();
      checks++;
      if ({frame_tick, led} !== exp_v) begin
        errors++;
        $display("FAIL chase_led cyc=%0d got=%h exp=%h", cyc, {frame_tick, led}, exp_v);
      end
      if (cyc >= 14 && cyc <= 27) begin
        c9  += int'(led[9]);
        c7a += int'(led[7]);
      end
      if (cyc >= 28 && cyc <= 41) c7b += int'(led[7]);
    end
    checks++;
    if (c9 !== 2) begin errors++; $display("FAIL chase_led9 got=%0d exp=%0d", c9, 2); end
    checks++;
    if (c7a !== 14) begin errors++; $display("FAIL chase_led7_f0 got=%0d exp=%0d", c7a, 14); end
    checks++;
    if (c7b !== 0) begin errors++; $display("FAIL chase_led7_f1 got=%0d exp=%0d", c7b, 0); end
  endtask

  task automatic test_random();
    int r0a, r0b;
    r0a = 0; r0b = 0;
    pattern_type = 2'd2;
    do_reset();
    for (int k = 0; k < 620; k++) begin
      step();
      exp_v = sb_q.pop_front();
      checks++;
      if ({frame_tick, led} !== exp_v) begin
        errors++;
        $display("FAIL random_led cyc=%0d got=%h exp=%h", cyc, {frame_tick, led}, exp_v);
      end
      if (cyc >= 14 && cyc <= 27) r0a += int'(led[0]);
      if (cyc >= 28 && cyc <= 41) r0b += int'(led[0]);
    end
    checks++;
    if (r0a !== 0) begin errors++; $display("FAIL random_f0 got=%0d exp=%0d", r0a, 0); end
    checks++;
    if (r0b !== 2) begin errors++; $display("FAIL random_f1 got=%0d exp=%0d", r0b, 2); end
  endtask

  task automatic test_reset_midrun();
    int budget;
    pattern_type = 2'd3;
    specific_led_values = 72'h4;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      if (cyc == 5) begin we = 1'b1; a = 8'd2; d = 72'h3F; end
      step();
      we = 1'b0;
      exp_v = sb_q.pop_front();
      checks++;
      if ({frame_tick, led} !== exp_v) begin
        errors++;
        $display("FAIL midrun_pre cyc=%0d got=%h exp=%h", cyc, {frame_tick, led}, exp_v);
      end
    end
    budget = 0;
    while (led[0] !== 1'b1 && budget < 20) begin
      step();
      void'(sb_q.pop_front());
      budget++;
    end
    checks++;
    if (led[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrun_find_high got=%b exp=%b", led[0], 1'b1);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({frame_tick, led} !== 25'd0) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", {frame_tick, led}, 25'd0);
    end
    do_reset();
    for (int k = 0; k < 210; k++) begin
      pattern_type = (cyc < 70) ? 2'd2 : 2'd1;
      step();
      exp_v = sb_q.pop_front();
      checks++;
      if ({frame_tick, led} !== exp_v) begin
        errors++;
        $display("FAIL midrun_post cyc=%0d got=%h exp=%h", cyc, {frame_tick, led}, exp_v);
      end
    end
  endtask

  initial begin
    seq[0] = SEED;
    for (int k = 1; k < 128; k++) begin
      seq[k] = {seq[k-1][14:0], seq[k-1][15] ^ seq[k-1][13] ^ seq[k-1][12] ^ seq[k-1][10]};
    end
    @(negedge clk);
    test_reset();
    test_individual();
    test_stored();
    test_chase();
    test_random();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
